// File: rtl/imm_target_pipe_if.sv
// rtl/imm_target_pipe_if.sv - handshake, flush and result bundle for imm_target_pipe
interface imm_target_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IR_W   = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] pc;
  logic [2:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] target;
  logic              err;

  modport master (
    output flush, in_valid, ir, pc, mode, out_ready,
    input  in_ready, out_valid, imm, target, err
  );

  modport slave (
    input  flush, in_valid, ir, pc, mode, out_ready,
    output in_ready, out_valid, imm, target, err
  );
endinterface

// File: rtl/imm_target_pipe.sv
// rtl/imm_target_pipe.sv - two-stage handshaked SPARC V8 immediate and branch-target generator
module imm_target_pipe #(
  parameter int DATA_W = 32,
  parameter int IR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  imm_target_pipe_if.slave  bus
);

  localparam logic [2:0] MODE_SIMM13 = 3'd0;
  localparam logic [2:0] MODE_SETHI  = 3'd1;
  localparam logic [2:0] MODE_DISP22 = 3'd2;
  localparam logic [2:0] MODE_BRANCH = 3'd3;
  localparam logic [2:0] MODE_CALL   = 3'd4;

  logic              s1_valid_q;
  logic [29:0]       s1_ir_q;
  logic [DATA_W-1:0] s1_pc_q;
  logic [2:0]        s1_mode_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] target_q;
  logic              err_q;

  logic [DATA_W-1:0] imm_d;
  logic [DATA_W-1:0] target_d;
  logic              err_d;

  logic s2_en;
  logic s1_en;
  logic in_ready;
  logic accept;

  // out_ready reaches in_ready combinationally so a full pipe refills in the release cycle
  assign s2_en    = !out_valid_q || bus.out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_ir_q    <= '0;
      s1_pc_q    <= '0;
      s1_mode_q  <= '0;
    end else if (bus.flush) begin
      s1_valid_q <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_ir_q   <= bus.ir[29:0];
        s1_pc_q   <= bus.pc;
        s1_mode_q <= bus.mode;
      end
    end
  end

  // Fields are pre-filled with their sign bit, then the low bits overwritten,
  // so extension to bit DATA_W-1 holds for any DATA_W >= 32.
  always_comb begin
    imm_d    = '0;
    target_d = '0;
    err_d    = 1'b0;
    case (s1_mode_q)
      MODE_SIMM13: begin
        imm_d       = {DATA_W{s1_ir_q[12]}};
        imm_d[12:0] = s1_ir_q[12:0];
      end
      MODE_SETHI: begin
        imm_d[31:0] = {s1_ir_q[21:0], 10'b0};
      end
      MODE_DISP22: begin
        imm_d       = {DATA_W{s1_ir_q[21]}};
        imm_d[21:0] = s1_ir_q[21:0];
      end
      MODE_BRANCH: begin
        imm_d       = {DATA_W{s1_ir_q[21]}};
        imm_d[23:0] = {s1_ir_q[21:0], 2'b00};
        target_d    = s1_pc_q + imm_d;
      end
      MODE_CALL: begin
        imm_d       = {DATA_W{s1_ir_q[29]}};
        imm_d[31:0] = {s1_ir_q[29:0], 2'b00};
        target_d    = s1_pc_q + imm_d;
      end
      default: begin
        err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      target_q    <= '0;
      err_q       <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        imm_q    <= imm_d;
        target_q <= target_d;
        err_q    <= err_d;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.imm       = imm_q;
  assign bus.target    = target_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_imm_target_pipe.sv
// tb/tb_imm_target_pipe.sv - directed and randomized checks of imm_target_pipe against a reference model
module tb_imm_target_pipe;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imm_target_pipe_if #(.DATA_W(32), .IR_W(32)) ifc ();
  imm_target_pipe_if #(.DATA_W(64), .IR_W(32)) if64 ();

  imm_target_pipe #(.DATA_W(32), .IR_W(32)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));
  imm_target_pipe #(.DATA_W(64), .IR_W(32)) dut64 (.clk(clk), .reset(reset), .bus(if64.slave));

  assign if64.flush     = ifc.flush;
  assign if64.in_valid  = ifc.in_valid;
  assign if64.ir        = ifc.ir;
  assign if64.pc        = {32'h0, ifc.pc};
  assign if64.mode      = ifc.mode;
  assign if64.out_ready = ifc.out_ready;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_xfer   = 0;
  bit   last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic longint sfield(input longint v, input int bits);
    return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
  endfunction

  function automatic exp_t model(input logic [2:0] m, input logic [31:0] ir, input logic [31:0] pc);
    exp_t   r;
    longint s;
    r = '0;
    s = 0;
    case (m)
      3'd0: s = sfield(longint'(ir & 32'h1FFF), 13);
      3'd1: s = longint'(ir & 32'h3F_FFFF) * 1024;
      3'd2: s = sfield(longint'(ir & 32'h3F_FFFF), 22);
      3'd3: s = 4 * sfield(longint'(ir & 32'h3F_FFFF), 22);
      3'd4: s = 4 * sfield(longint'(ir & 32'h3FFF_FFFF), 30);
      default: r.err = 1'b1;
    endcase
    r.imm = 32'(s);
    if (m == 3'd3 || m == 3'd4) r.tgt = 32'(longint'(pc) + s);
    return r;
  endfunction

  // One clock: check in_ready against occupancy, score any output transfer, then advance.
  task automatic step();
    bit          xfer, hold;
    logic [31:0] h_imm, h_tgt;
    logic        h_err;
    exp_t        e;
    #1;
    chk("in_ready", ifc.in_ready, !ifc.flush && (q.size() < 2 || ifc.out_ready));
    last_acc = ifc.in_valid && ifc.in_ready;
    xfer     = ifc.out_valid && ifc.out_ready;
    hold     = ifc.out_valid && !ifc.out_ready && !ifc.flush;
    h_imm    = ifc.imm;
    h_tgt    = ifc.target;
    h_err    = ifc.err;
    if (xfer && !ifc.flush) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        chk("sb_imm", ifc.imm, e.imm);
        chk("sb_target", ifc.target, e.tgt);
        chk("sb_err", ifc.err, e.err);
        n_xfer++;
      end
    end
    if (ifc.flush) q.delete();
    else if (last_acc) q.push_back(model(ifc.mode, ifc.ir, ifc.pc));
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", ifc.out_valid, 1'b1);
      chk("hold_imm", ifc.imm, h_imm);
      chk("hold_target", ifc.target, h_tgt);
      chk("hold_err", ifc.err, h_err);
    end
  endtask

  task automatic drive(input logic [2:0] m, input logic [31:0] ir, input logic [31:0] pc);
    ifc.mode = m;
    ifc.ir   = ir;
    ifc.pc   = pc;
  endtask

  task automatic drive_rand();
    drive(3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  // Present one input to an empty pipe and check the result two edges later.
  task automatic send_check(input string tag, input logic [2:0] m, input logic [31:0] ir,
                            input logic [31:0] pc, input logic [31:0] e_imm,
                            input logic [31:0] e_tgt, input logic e_err);
    drive(m, ir, pc);
    ifc.in_valid  = 1'b1;
    ifc.out_ready = 1'b1;
    step();
    ifc.in_valid = 1'b0;
    chk({tag, "_early"}, ifc.out_valid, 1'b0);
    step();
    chk({tag, "_valid"}, ifc.out_valid, 1'b1);
    chk({tag, "_imm"}, ifc.imm, e_imm);
    chk({tag, "_target"}, ifc.target, e_tgt);
    chk({tag, "_err"}, ifc.err, e_err);
  endtask

  initial begin
    int acc_cnt;
    int x0;
    int guard;

    reset         = 1'b1;
    ifc.flush     = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    drive(3'd0, 32'h0, 32'h0);
    #12;
    chk("rst_valid", ifc.out_valid, 1'b0);
    chk("rst_imm", ifc.imm, 32'h0);
    chk("rst_err", ifc.err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", ifc.in_ready, 1'b1);

    send_check("m0_neg", 3'd0, 32'h0000_1FFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    chk("m0_neg_64", if64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    send_check("m0_pos", 3'd0, 32'h0000_0FFF, 32'h0, 32'h0000_0FFF, 32'h0, 1'b0);
    chk("m0_pos_64", if64.imm, 64'h0000_0000_0000_0FFF);
    step();
    send_check("m3", 3'd3, 32'h003F_FFFF, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0);
    step();
    send_check("m4_wrap", 3'd4, 32'h0000_0008, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0010, 1'b0);
    step();
    send_check("m1", 3'd1, 32'h003A_BCDE, 32'h1234_5678, 32'hEAF3_7800, 32'h0, 1'b0);
    step();
    send_check("m6", 3'd6, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h0, 1'b1);
    step();

    // Back-pressure: four inputs against a stalled consumer
    x0            = n_xfer;
    acc_cnt       = 0;
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    drive_rand();
    for (int i = 0; i < 5; i++) begin
      step();
      if (last_acc) begin
        acc_cnt++;
        drive_rand();
      end
    end
    chk("bp_accepted", 32'(acc_cnt), 32'd2);
    #1;
    chk("bp_in_ready", ifc.in_ready, 1'b0);
    ifc.out_ready = 1'b1;
    guard = 0;
    while (acc_cnt < 4 && guard < 20) begin
      step();
      if (last_acc) begin
        acc_cnt++;
        drive_rand();
      end
      guard++;
    end
    ifc.in_valid = 1'b0;
    guard = 0;
    while (n_xfer - x0 < 4 && guard < 20) begin
      step();
      guard++;
    end
    chk("bp_delivered", 32'(n_xfer - x0), 32'd4);
    step();
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Flush with both stages full and input pending
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    drive_rand();
    for (int i = 0; i < 3; i++) step();
    ifc.flush = 1'b1;
    #1;
    chk("flush_in_ready", ifc.in_ready, 1'b0);
    step();
    ifc.flush    = 1'b0;
    ifc.in_valid = 1'b0;
    chk("flush_valid", ifc.out_valid, 1'b0);
    send_check("post_flush", 3'd2, 32'h0020_0001, 32'h0, 32'hFFE0_0001, 32'h0, 1'b0);
    step();

    // Reset asserted between edges with both stages full
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    drive(3'd4, 32'h1234_5678, 32'h4000_0000);
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_full", ifc.out_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", ifc.out_valid, 1'b0);
    chk("midrst_imm", ifc.imm, 32'h0);
    chk("midrst_target", ifc.target, 32'h0);
    chk("midrst_err", ifc.err, 1'b0);
    q.delete();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", ifc.in_ready, 1'b1);

    // Randomized traffic scored against the model
    for (int i = 0; i < 400; i++) begin
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      ifc.flush     = ($urandom_range(0, 24) == 0);
      if (!(ifc.out_valid && !ifc.out_ready && !ifc.flush) || 1'b1) drive_rand();
      step();
    end
    ifc.flush     = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("final_empty", 32'(q.size()), 32'd0);
    chk("final_valid", ifc.out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
